dma_burst_mem_responder: RTL and testbench
==========================================

Name: dma_burst_mem_responder

Overview:
- Memory-side responder for the DMA engine's burst read and write channels.
- Accepts read and write burst requests and serves them from an internal word-addressed RAM.
- Returns read bursts with a last-beat marker and absorbs write bursts.
- Serves as the slave model in engine-level simulation and as a small on-chip scratch memory target.

Parameters:
DATA_WIDTH, 32, data beat width in bits.
MEM_AW, 10, word-address width of the internal RAM (2^MEM_AW words).

Ports:
clk  input  1  clock
rst_n  input  1  reset
rd_req_addr  input  32  byte address of the first read beat
rd_req_len  input  5  read beats minus 1
rd_req_valid  input  1  read request valid
rd_req_ready  output  1  read request accepted
rd_rdata  output  DATA_WIDTH  read beat data
rd_valid  output  1  read beat valid
rd_last  output  1  final beat of the read burst
rd_ready  input  1  master accepts the read beat
wr_req_addr  input  32  byte address of the first write beat
wr_req_len  input  5  write beats minus 1
wr_req_valid  input  1  write request valid
wr_req_ready  output  1  write request accepted
wr_data  input  DATA_WIDTH  write beat data
wr_valid  input  1  write beat valid
wr_ready  output  1  responder accepts the write beat
wr_last  input  1  master marks the final write beat
err_clr  input  1  clears err
busy  output  1  burst in progress
err  output  1  sticky protocol error

Behaviour:
- Reset: already decided — one clock (clk); reset is asynchronous and active-low (rst_n).
- Values held during reset:
  - state = IDLE; prio = READ.
  - rd_valid, rd_last, busy, err, rd_req_ready, wr_req_ready and wr_ready all 0.
  - rd_rdata = 0; beat counter = 0.
  - RAM contents are not reset.
- States are IDLE, RD and WR. Only one burst is in flight at a time.

Request acceptance (IDLE only):
- rd_req_ready = IDLE && (!wr_req_valid || prio==READ).
- wr_req_ready = IDLE && (!rd_req_valid || prio==WRITE).
- Both readies are combinational; neither depends on its own valid.
- If both valids are high in IDLE, the channel named by prio wins, and prio toggles on every accepted request.
- On accept:
  - ptr = addr[MEM_AW+1:2]; addr[1:0] is ignored.
  - len is latched; cnt = 0.
  - Next state is RD or WR.
  - Request inputs are not sampled again until the next IDLE.

Read (RD):
- The cycle after accept: rd_valid = 1, rd_rdata = mem[ptr] (registered), rd_last = (cnt==len).
- On rd_valid && rd_ready:
  - If not last: cnt+1 and ptr+1, and the next beat is presented in the following cycle with no bubble.
  - If last: rd_valid drops and the state returns to IDLE.
- While rd_ready = 0: rd_rdata, rd_valid and rd_last hold stable.
- A burst of len+1 beats occupies exactly len+2 cycles from accept with no backpressure.

Write (WR):
- wr_ready = 1 throughout WR.
- On wr_valid && wr_ready: mem[ptr] <= wr_data; cnt+1; ptr+1.
- The beat with cnt==len ends the burst and the state returns to IDLE next cycle.
- If wr_last != (cnt==len) on any accepted beat, err is set. The burst still terminates by count, never by wr_last.

Addressing:
- ptr wraps modulo 2^MEM_AW; a burst crossing the top of the RAM continues at word 0.
- Upper address bits above MEM_AW+1 are ignored.

Simultaneous access:
- A write and a read of the same word cannot overlap, since bursts are serialized.
- A read issued after a write returns the written data.

err and busy:
- err is sticky. err_clr clears it; set wins if both occur in the same cycle.
- busy = (state != IDLE).

Reset mid-burst:
- Aborts immediately to IDLE with rd_valid = 0 and wr_ready = 0.
- Writes already accepted remain in RAM.

len = 0 is a single-beat burst (rd_last on the first beat).

Test Plan:
- Write burst addr 0x40, len 7, data 0x100..0x107 with wr_last on beat 7 → mem[0x10..0x17] written, err = 0, busy low one cycle after the last beat.
- Read burst addr 0x40, len 7, rd_ready held high → rd_valid for 8 consecutive cycles, data 0x100..0x107, rd_last only on the 8th beat, accept-to-IDLE in 9 cycles.
- Same read with rd_ready toggled 1,0,0,1,... → each beat holds stable while stalled, no beats lost or duplicated, rd_last on 0x107.
- rd_req_valid and wr_req_valid raised together for three consecutive requests after reset → accept order is read, write, read.
- Write len 3 with wr_last asserted on beat 1 → err = 1, all 4 beats still written; err_clr pulse → err = 0.
- Write at word 2^MEM_AW-2, len 3, then read back → words wrap to 0 and 1; rst_n pulsed low mid-read → rd_valid drops asynchronously, state IDLE.

Source files
------------

// File: rtl/dma_burst_mem_responder_if.sv
// Burst request/response bundle between the DMA engine (master) and the
// memory-side responder (slave).
//   rd_req_*  : read burst request (byte address, beats-1, valid/ready)
//   rd_*      : read data beats back to the master, rd_last on the final beat
//   wr_req_*  : write burst request (byte address, beats-1, valid/ready)
//   wr_*      : write data beats from the master, wr_last marks the final beat
//   err_clr   : clears the sticky protocol error
//   busy, err : responder status
interface dma_burst_mem_responder_if #(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           rd_req_addr;
    logic [4:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;
    logic [31:0]           wr_req_addr;
    logic [4:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_ready;
    logic                  wr_last;
    logic                  err_clr;
    logic                  busy;
    logic                  err;

    modport master (
        output rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        output wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        output err_clr,
        input  rd_req_ready, rd_rdata, rd_valid, rd_last,
        input  wr_req_ready, wr_ready, busy, err
    );

    modport slave (
        input  rd_req_addr, rd_req_len, rd_req_valid, rd_ready,
        input  wr_req_addr, wr_req_len, wr_req_valid, wr_data, wr_valid, wr_last,
        input  err_clr,
        output rd_req_ready, rd_rdata, rd_valid, rd_last,
        output wr_req_ready, wr_ready, busy, err
    );
endinterface

// File: rtl/dma_burst_mem_responder.sv
// Memory-side responder for the DMA burst read/write channels. Serves one
// burst at a time from an internal word-addressed RAM of 2^MEM_AW words.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (RAM contents are kept)
//   bus   : slave side of dma_burst_mem_responder_if
//
// state | meaning
// IDLE  | waiting for a read or write request
// RD    | presenting read beats to the master
// WR    | absorbing write beats from the master
module dma_burst_mem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_AW     = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    dma_burst_mem_responder_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    localparam logic PRIO_READ  = 1'b0;
    localparam logic PRIO_WRITE = 1'b1;

    state_t                state_q;
    state_t                state_d;
    logic                  prio_q;
    logic [MEM_AW-1:0]     ptr_q;
    logic [MEM_AW-1:0]     ptr_inc;
    logic [4:0]            len_q;
    logic [4:0]            cnt_q;
    logic [DATA_WIDTH-1:0] rd_rdata_q;
    logic                  rd_valid_q;
    logic                  rd_last_q;
    logic                  err_q;

    logic                  rd_req_ready;
    logic                  wr_req_ready;
    logic                  rd_accept;
    logic                  wr_accept;
    logic                  rd_beat;
    logic                  wr_beat;
    logic                  wr_done;
    logic                  wr_last_bad;

    logic [DATA_WIDTH-1:0] mem [0:(1<<MEM_AW)-1];

    // Address bits outside the RAM word range are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.rd_req_addr[31:MEM_AW+2], bus.rd_req_addr[1:0],
                                bus.wr_req_addr[31:MEM_AW+2], bus.wr_req_addr[1:0]};

    // Readies are gated by rst_n so they read 0 while reset is held.
    assign rd_req_ready = rst_n && (state_q == IDLE) &&
                          (!bus.wr_req_valid || (prio_q == PRIO_READ));
    assign wr_req_ready = rst_n && (state_q == IDLE) &&
                          (!bus.rd_req_valid || (prio_q == PRIO_WRITE));
    assign rd_accept    = bus.rd_req_valid && rd_req_ready;
    assign wr_accept    = bus.wr_req_valid && wr_req_ready;

    assign ptr_inc      = ptr_q + MEM_AW'(1);
    assign rd_beat      = (state_q == RD) && rd_valid_q && bus.rd_ready;
    assign wr_beat      = (state_q == WR) && bus.wr_valid;
    assign wr_done      = wr_beat && (cnt_q == len_q);
    assign wr_last_bad  = wr_beat && (bus.wr_last != (cnt_q == len_q));

    assign bus.rd_req_ready = rd_req_ready;
    assign bus.wr_req_ready = wr_req_ready;
    assign bus.rd_rdata     = rd_rdata_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_last      = rd_last_q;
    assign bus.wr_ready     = (state_q == WR);
    assign bus.busy         = (state_q != IDLE);
    assign bus.err          = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rd_accept) begin
                    state_d = RD;
                end else if (wr_accept) begin
                    state_d = WR;
                end
            end
            RD: begin
                if (rd_beat && rd_last_q) begin
                    state_d = IDLE;
                end
            end
            WR: begin
                if (wr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q     <= PRIO_READ;
            ptr_q      <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            rd_rdata_q <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (rd_accept) begin
                prio_q     <= ~prio_q;
                ptr_q      <= bus.rd_req_addr[MEM_AW+1:2];
                len_q      <= bus.rd_req_len;
                cnt_q      <= '0;
                rd_rdata_q <= mem[bus.rd_req_addr[MEM_AW+1:2]];
                rd_valid_q <= 1'b1;
                rd_last_q  <= (bus.rd_req_len == 5'd0);
            end else if (wr_accept) begin
                prio_q <= ~prio_q;
                ptr_q  <= bus.wr_req_addr[MEM_AW+1:2];
                len_q  <= bus.wr_req_len;
                cnt_q  <= '0;
            end else if (rd_beat) begin
                if (rd_last_q) begin
                    rd_valid_q <= 1'b0;
                    rd_last_q  <= 1'b0;
                end else begin
                    // Fetch the next word now so it is presented without a bubble.
                    ptr_q      <= ptr_inc;
                    cnt_q      <= cnt_q + 5'd1;
                    rd_rdata_q <= mem[ptr_inc];
                    rd_last_q  <= ((cnt_q + 5'd1) == len_q);
                end
            end else if (wr_beat) begin
                ptr_q <= ptr_inc;
                cnt_q <= cnt_q + 5'd1;
            end

            // Set wins over clear.
            if (wr_last_bad) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    // wr_beat is qualified by state, which resets asynchronously, so no write
    // can land while reset is held.
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            mem[ptr_q] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_dma_burst_mem_responder.sv
module tb_dma_burst_mem_responder;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dma_burst_mem_responder_if #(.DATA_WIDTH(32)) bus_if ();

    dma_burst_mem_responder #(
        .DATA_WIDTH(32),
        .MEM_AW    (10)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [4:0] len,
                               input logic [31:0] base, input int last_pos);
        step();
        bus_if.wr_req_addr  = addr;
        bus_if.wr_req_len   = len;
        bus_if.wr_req_valid = 1'b1;
        @(negedge clk);
        chk("wr_req_ready", 32'(bus_if.wr_req_ready), 32'd1);
        step();
        bus_if.wr_req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            bus_if.wr_valid = 1'b1;
            bus_if.wr_data  = base + 32'(i);
            bus_if.wr_last  = (i == last_pos);
            @(negedge clk);
            chk("wr_ready", 32'(bus_if.wr_ready), 32'd1);
            step();
        end
        bus_if.wr_valid = 1'b0;
        bus_if.wr_last  = 1'b0;
        @(negedge clk);
        chk("wr_end_busy", 32'(bus_if.busy), 32'd0);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [4:0] len,
                              input logic [31:0] base);
        step();
        bus_if.rd_req_addr  = addr;
        bus_if.rd_req_len   = len;
        bus_if.rd_req_valid = 1'b1;
        bus_if.rd_ready     = 1'b1;
        @(negedge clk);
        chk("rd_req_ready", 32'(bus_if.rd_req_ready), 32'd1);
        step();
        bus_if.rd_req_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            chk("rd_valid", 32'(bus_if.rd_valid), 32'd1);
            chk("rd_rdata", bus_if.rd_rdata, base + 32'(i));
            chk("rd_last", 32'(bus_if.rd_last), 32'(i == int'(len)));
            step();
        end
        @(negedge clk);
        chk("rd_end_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rd_end_busy", 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int b;
        int cyc;
        checks   = 0;
        failures = 0;

        rst_n               = 1'b0;
        bus_if.rd_req_addr  = '0;
        bus_if.rd_req_len   = '0;
        bus_if.rd_req_valid = 1'b0;
        bus_if.rd_ready     = 1'b0;
        bus_if.wr_req_addr  = '0;
        bus_if.wr_req_len   = '0;
        bus_if.wr_req_valid = 1'b0;
        bus_if.wr_data      = '0;
        bus_if.wr_valid     = 1'b0;
        bus_if.wr_last      = 1'b0;
        bus_if.err_clr      = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("rst_rd_last", 32'(bus_if.rd_last), 32'd0);
        chk("rst_rd_rdata", bus_if.rd_rdata, 32'd0);
        chk("rst_busy", 32'(bus_if.busy), 32'd0);
        chk("rst_err", 32'(bus_if.err), 32'd0);
        chk("rst_rd_req_ready", 32'(bus_if.rd_req_ready), 32'd0);
        chk("rst_wr_req_ready", 32'(bus_if.wr_req_ready), 32'd0);
        chk("rst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
        rst_n = 1'b1;

        // Arbitration: both valids high for three requests -> read, write, read
        step();
        bus_if.rd_req_addr  = 32'h20;
        bus_if.rd_req_len   = 5'd0;
        bus_if.rd_req_valid = 1'b1;
        bus_if.rd_ready     = 1'b1;
        bus_if.wr_req_addr  = 32'h20;
        bus_if.wr_req_len   = 5'd0;
        bus_if.wr_req_valid = 1'b1;
        bus_if.wr_valid     = 1'b1;
        bus_if.wr_data      = 32'hAA;
        bus_if.wr_last      = 1'b1;
        @(negedge clk);
        chk("arb1_rd_req_ready", 32'(bus_if.rd_req_ready), 32'd1);
        chk("arb1_wr_req_ready", 32'(bus_if.wr_req_ready), 32'd0);
        step();
        @(negedge clk);
        chk("arb1_busy", 32'(bus_if.busy), 32'd1);
        chk("arb1_rd_valid", 32'(bus_if.rd_valid), 32'd1);
        chk("arb1_rd_last", 32'(bus_if.rd_last), 32'd1);
        chk("arb1_wr_ready", 32'(bus_if.wr_ready), 32'd0);
        step();
        @(negedge clk);
        chk("arb2_busy", 32'(bus_if.busy), 32'd0);
        chk("arb2_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("arb2_rd_req_ready", 32'(bus_if.rd_req_ready), 32'd0);
        chk("arb2_wr_req_ready", 32'(bus_if.wr_req_ready), 32'd1);
        step();
        @(negedge clk);
        chk("arb2_wr_ready", 32'(bus_if.wr_ready), 32'd1);
        step();
        bus_if.wr_valid = 1'b0;
        bus_if.wr_last  = 1'b0;
        @(negedge clk);
        chk("arb3_busy", 32'(bus_if.busy), 32'd0);
        chk("arb3_err", 32'(bus_if.err), 32'd0);
        chk("arb3_rd_req_ready", 32'(bus_if.rd_req_ready), 32'd1);
        chk("arb3_wr_req_ready", 32'(bus_if.wr_req_ready), 32'd0);
        step();
        bus_if.rd_req_valid = 1'b0;
        bus_if.wr_req_valid = 1'b0;
        @(negedge clk);
        chk("arb3_rd_valid", 32'(bus_if.rd_valid), 32'd1);
        chk("arb3_rd_rdata", bus_if.rd_rdata, 32'hAA);
        step();
        @(negedge clk);
        chk("arb3_end_busy", 32'(bus_if.busy), 32'd0);

        // Write burst 0x40 len 7, then read it back with rd_ready held high
        write_burst(32'h40, 5'd7, 32'h100, 7);
        chk("wr40_err", 32'(bus_if.err), 32'd0);
        read_burst(32'h40, 5'd7, 32'h100);

        // Same read with backpressure pattern 1,0,0,1,0,0,...
        step();
        bus_if.rd_req_addr  = 32'h40;
        bus_if.rd_req_len   = 5'd7;
        bus_if.rd_req_valid = 1'b1;
        @(negedge clk);
        chk("stall_req_ready", 32'(bus_if.rd_req_ready), 32'd1);
        step();
        bus_if.rd_req_valid = 1'b0;
        b   = 0;
        cyc = 0;
        while (b < 8 && cyc < 60) begin
            bus_if.rd_ready = (cyc % 3 == 0);
            @(negedge clk);
            chk("stall_rd_valid", 32'(bus_if.rd_valid), 32'd1);
            chk("stall_rd_rdata", bus_if.rd_rdata, 32'h100 + 32'(b));
            chk("stall_rd_last", 32'(bus_if.rd_last), 32'(b == 7));
            if (bus_if.rd_ready) b++;
            step();
            cyc++;
        end
        chk("stall_beats", 32'(b), 32'd8);
        bus_if.rd_ready = 1'b1;
        @(negedge clk);
        chk("stall_end_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("stall_end_busy", 32'(bus_if.busy), 32'd0);

        // Early wr_last: err set, burst still runs to count
        write_burst(32'h200, 5'd3, 32'h300, 1);
        chk("errw_err", 32'(bus_if.err), 32'd1);
        read_burst(32'h200, 5'd3, 32'h300);
        chk("errw_sticky", 32'(bus_if.err), 32'd1);
        step();
        bus_if.err_clr = 1'b1;
        step();
        bus_if.err_clr = 1'b0;
        @(negedge clk);
        chk("errclr_err", 32'(bus_if.err), 32'd0);

        // Wrap at the top of RAM (word 1022), upper and low address bits ignored
        write_burst(32'h1000_0FFB, 5'd3, 32'h500, 3);
        chk("wrap_err", 32'(bus_if.err), 32'd0);
        read_burst(32'h0, 5'd1, 32'h502);

        // Reset mid-read
        step();
        bus_if.rd_req_addr  = 32'hFF8;
        bus_if.rd_req_len   = 5'd3;
        bus_if.rd_req_valid = 1'b1;
        bus_if.rd_ready     = 1'b1;
        @(negedge clk);
        chk("mrst_req_ready", 32'(bus_if.rd_req_ready), 32'd1);
        step();
        bus_if.rd_req_valid = 1'b0;
        @(negedge clk);
        chk("mrst_beat0", bus_if.rd_rdata, 32'h500);
        step();
        @(negedge clk);
        chk("mrst_beat1", bus_if.rd_rdata, 32'h501);
        rst_n = 1'b0;
        #1;
        chk("mrst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
        chk("mrst_busy", 32'(bus_if.busy), 32'd0);
        chk("mrst_wr_ready", 32'(bus_if.wr_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        read_burst(32'hFF8, 5'd3, 32'h500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
